// File: rtl/mt_stream_adapter_pkg.sv
// Shared types for the Mersenne-twister stream adapter.
//   mt_word_t  : one 32-bit tempered generator word
//   mt_entry_t : one buffered result (data word plus end-of-block tag)
//   MT_MUL_W   : width of the full scaling product
package mt_pkg;

  typedef logic [31:0] mt_word_t;

  typedef struct packed {
    mt_word_t data;
    logic     last;
  } mt_entry_t;

  localparam int MT_MUL_W = 64;

endpackage

// File: rtl/mt_stream_adapter_if.sv
// Handshake bundle for the stream adapter.
//   Generator side : gen_trig (request), gen_ready, gen_last, gen_num (word, cycle after trig)
//   Consumer side  : out_valid, out_ready, out_data, out_last
// master = adapter view, slave = generator/consumer environment view.
interface mt_stream_adapter_if;
  import mt_pkg::*;

  logic     gen_trig;
  logic     gen_ready;
  logic     gen_last;
  mt_word_t gen_num;
  logic     out_valid;
  logic     out_ready;
  mt_word_t out_data;
  logic     out_last;

  modport master (
    output gen_trig, out_valid, out_data, out_last,
    input  gen_ready, gen_last, gen_num, out_ready
  );

  modport slave (
    input  gen_trig, out_valid, out_data, out_last,
    output gen_ready, gen_last, gen_num, out_ready
  );

endinterface

// File: rtl/mt_stream_adapter_fifo.sv
// Register-based synchronous FIFO, first-word-fall-through.
//   clk, rst          : clock, synchronous active-high reset (storage cleared too)
//   push, push_data   : write one entry
//   pop, pop_data     : pop_data always shows the head entry (registered storage)
//   full, empty, count: occupancy
module mt_sync_fifo
  import mt_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = mt_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/mt_stream_adapter.sv
// Consumer of the Mersenne-twister generator: requests words, optionally scales
// them into [0,bound) by multiply-high, buffers them and streams them out.
//   clk, rst : clock, synchronous active-high reset
//   en       : allow new trig requests (in-flight words still land when low)
//   bound    : scaling range, 0 = raw word; captured together with the word
//   bus      : generator handshake (gen_*) and output stream (out_*)
module mt_stream_adapter
  import mt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  mt_word_t             bound,
  mt_stream_adapter_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  mt_entry_t           push_entry;
  mt_entry_t           pop_entry;
  logic                push;
  logic                pop;
  logic                gen_trig;
  logic [CNT_W:0]      credit_used;
  logic [MT_MUL_W-1:0] prod;

  logic       trig_q, trig_d;
  logic       trig_last_q, trig_last_d;
  logic [1:0] inflight_q, inflight_d;
  logic       s1_valid_q, s1_valid_d;
  mt_word_t   s1_num_q, s1_num_d;
  mt_word_t   s1_bound_q, s1_bound_d;
  logic       s1_last_q, s1_last_d;

  always_comb begin
    // Credit uses registered occupancy only; a same-cycle pop is not credited,
    // which keeps the issue path free of the output handshake.
    credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
    gen_trig    = !rst && en && bus.gen_ready && (credit_used < (CNT_W+1)'(DEPTH));

    trig_d      = gen_trig;
    trig_last_d = gen_trig && bus.gen_last;

    // S1 captures the word the cycle after trig; bound is frozen here.
    s1_valid_d = trig_q;
    s1_num_d   = trig_q ? bus.gen_num     : s1_num_q;
    s1_bound_d = trig_q ? bound           : s1_bound_q;
    s1_last_d  = trig_q ? trig_last_q     : s1_last_q;

    prod            = MT_MUL_W'(s1_num_q) * MT_MUL_W'(s1_bound_q);
    push            = s1_valid_q;
    push_entry.data = (s1_bound_q == '0) ? s1_num_q : 32'(prod >> 32);
    push_entry.last = s1_last_q;

    pop        = !fifo_empty && bus.out_ready;
    inflight_d = inflight_q + 2'(gen_trig) - 2'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q      <= 1'b0;
      trig_last_q <= 1'b0;
      inflight_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_num_q    <= '0;
      s1_bound_q  <= '0;
      s1_last_q   <= 1'b0;
    end else begin
      trig_q      <= trig_d;
      trig_last_q <= trig_last_d;
      inflight_q  <= inflight_d;
      s1_valid_q  <= s1_valid_d;
      s1_num_q    <= s1_num_d;
      s1_bound_q  <= s1_bound_d;
      s1_last_q   <= s1_last_d;
    end
  end

  mt_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (mt_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The credit check must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

  assign bus.gen_trig  = gen_trig;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = pop_entry.data;
  assign bus.out_last  = pop_entry.last;

endmodule

// File: tb/tb_mt_stream_adapter.sv
// Directed bench for mt_stream_adapter with a behavioural MT19937 generator.
module tb_mt_stream_adapter;
  import mt_pkg::*;

  localparam int DEPTH  = 8;
  localparam int REFILL = 12;
  localparam int NGOLD  = 3 * 624;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     en = 1'b0;
  mt_word_t bound = '0;

  mt_stream_adapter_if bus ();

  mt_stream_adapter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .bound (bound),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  mt_word_t golden [NGOLD];
  int       gen_idx = 0;
  int       refill_cnt = 0;
  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;

  mt_word_t rx_data [$];
  logic     rx_last [$];
  int       rx_cyc [$];
  int       trig_cnt, push_cnt, first_trig_cyc, first_valid_cyc, trig_in_refill;

  // Generator model: word valid the cycle after trig, refill gap after word 624.
  assign bus.gen_ready = !rst && (refill_cnt == 0);
  assign bus.gen_last  = ((gen_idx % 624) == 623);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      gen_idx     <= 0;
      refill_cnt  <= 0;
      bus.gen_num <= '0;
    end else if (bus.gen_trig) begin
      bus.gen_num <= golden[gen_idx % NGOLD];
      gen_idx     <= gen_idx + 1;
      if ((gen_idx % 624) == 623) refill_cnt <= REFILL;
    end else if (refill_cnt != 0) begin
      refill_cnt <= refill_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      rx_data.delete();
      rx_last.delete();
      rx_cyc.delete();
      trig_cnt        = 0;
      push_cnt        = 0;
      first_trig_cyc  = -1;
      first_valid_cyc = -1;
      trig_in_refill  = 0;
    end else begin
      if (bus.gen_trig) begin
        trig_cnt++;
        if (first_trig_cyc < 0) first_trig_cyc = cyc;
        if (refill_cnt != 0) trig_in_refill++;
      end
      if (dut.push) push_cnt++;
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        rx_data.push_back(bus.out_data);
        rx_last.push_back(bus.out_last);
        rx_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic build_golden();
    mt_word_t mt [624];
    mt_word_t y;
    int       n;
    mt[0] = 32'd5489;
    for (int i = 1; i < 624; i++)
      mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
    n = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 624; i++) begin
        y = (mt[i] & 32'h8000_0000) | (mt[(i+1) % 624] & 32'h7fff_ffff);
        mt[i] = mt[(i+397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908_b0df : 32'h0);
      end
      for (int i = 0; i < 624; i++) begin
        y = mt[i];
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9d2c_5680);
        y = y ^ ((y << 15) & 32'hefc6_0000);
        y = y ^ (y >> 18);
        golden[n] = y;
        n++;
      end
    end
  endtask

  function automatic mt_word_t scale(input mt_word_t w, input mt_word_t b);
    logic [63:0] p;
    p = {32'b0, w} * {32'b0, b};
    return (b == 0) ? w : p[63:32];
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    en            = 1'b0;
    bound         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (rx_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; bound = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.gen_trig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b expected 0", bus.gen_trig); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", bus.out_last); end
    checks++; if (dut.inflight_q !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", dut.inflight_q); end
    checks++; if (dut.fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dut.fifo_count); end
    en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_raw();
    bit ok;
    int bad;
    do_reset();
    en = 1'b1;
    wait_rx(20, 200, ok);
    en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL raw_timeout: got %0d words expected 20", rx_data.size()); end
    checks++; if (rx_data[0] !== 32'hD091BB5C) begin errors++; $display("FAIL raw_word0: got %h expected D091BB5C", rx_data[0]); end
    checks++; if (rx_data[1] !== 32'h22AE9EF6) begin errors++; $display("FAIL raw_word1: got %h expected 22AE9EF6", rx_data[1]); end
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (rx_data[i] !== golden[i] || rx_last[i] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL raw_sequence: got %0d bad words expected 0", bad); end
    checks++; if (first_valid_cyc - first_trig_cyc != 3) begin errors++; $display("FAIL raw_latency: got %0d expected 3", first_valid_cyc - first_trig_cyc); end
    checks++; if (rx_cyc[19] - rx_cyc[0] != 19) begin errors++; $display("FAIL raw_throughput: got %0d cycles expected 19", rx_cyc[19] - rx_cyc[0]); end
  endtask

  task automatic test_scaled();
    bit ok;
    int bad_rng, bad_val;
    do_reset();
    bound = 32'd6;
    en = 1'b1;
    wait_rx(30, 200, ok);
    en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL scaled_timeout: got %0d words expected 30", rx_data.size()); end
    checks++; if (rx_data[0] !== 32'd4) begin errors++; $display("FAIL scaled_word0: got %0d expected 4", rx_data[0]); end
    checks++; if (rx_data[1] !== 32'd0) begin errors++; $display("FAIL scaled_word1: got %0d expected 0", rx_data[1]); end
    bad_rng = 0; bad_val = 0;
    for (int i = 0; i < 30; i++) begin
      if (rx_data[i] >= 32'd6) bad_rng++;
      if (rx_data[i] !== scale(golden[i], 32'd6)) bad_val++;
    end
    checks++; if (bad_rng != 0) begin errors++; $display("FAIL scaled_range: got %0d words >= 6 expected 0", bad_rng); end
    checks++; if (bad_val != 0) begin errors++; $display("FAIL scaled_values: got %0d bad words expected 0", bad_val); end
  endtask

  task automatic test_stall();
    bit ok;
    int unstable, bad;
    do_reset();
    bus.out_ready = 1'b0;
    en = 1'b1;
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid && (bus.out_data !== golden[0] || bus.out_last !== 1'b0)) unstable++;
    end
    checks++; if (trig_cnt != DEPTH) begin errors++; $display("FAIL stall_trigs: got %0d expected %0d", trig_cnt, DEPTH); end
    checks++; if (bus.gen_trig !== 1'b0) begin errors++; $display("FAIL stall_trig_now: got %b expected 0", bus.gen_trig); end
    checks++; if (dut.fifo_count !== 4'(DEPTH)) begin errors++; $display("FAIL stall_count: got %0d expected %0d", dut.fifo_count, DEPTH); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", bus.out_valid); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_hold: got %0d changed cycles expected 0", unstable); end
    bus.out_ready = 1'b1;
    wait_rx(40, 200, ok);
    en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d words expected 40", rx_data.size()); end
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (rx_data[i] !== golden[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_resume: got %0d bad words expected 0", bad); end
  endtask

  task automatic test_blocks();
    bit ok;
    int bad_data, bad_last;
    do_reset();
    en = 1'b1;
    wait_rx(1250, 3000, ok);
    en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL blocks_timeout: got %0d words expected 1250", rx_data.size()); end
    bad_data = 0; bad_last = 0;
    for (int i = 0; i < 1250; i++) begin
      if (rx_data[i] !== golden[i]) bad_data++;
      if (rx_last[i] !== ((i == 623 || i == 1247) ? 1'b1 : 1'b0)) bad_last++;
    end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL blocks_data: got %0d bad words expected 0", bad_data); end
    checks++; if (bad_last != 0) begin errors++; $display("FAIL blocks_last: got %0d bad tags expected 0", bad_last); end
    checks++; if (trig_in_refill != 0) begin errors++; $display("FAIL blocks_refill_trig: got %0d expected 0", trig_in_refill); end
  endtask

  task automatic test_en_toggle();
    bit ok;
    int snap_trig, snap_push, bad;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (trig_cnt >= 10) break;
    end
    en = 1'b0;
    snap_trig = trig_cnt;
    snap_push = push_cnt;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (trig_cnt != snap_trig) begin errors++; $display("FAIL en_trig_stop: got %0d expected %0d", trig_cnt, snap_trig); end
    checks++; if (push_cnt - snap_push > 2) begin errors++; $display("FAIL en_late_push: got %0d expected <=2", push_cnt - snap_push); end
    checks++; if (push_cnt != snap_trig) begin errors++; $display("FAIL en_inflight_land: got %0d pushes expected %0d", push_cnt, snap_trig); end
    checks++; if (rx_data.size() != snap_trig) begin errors++; $display("FAIL en_drain: got %0d words expected %0d", rx_data.size(), snap_trig); end
    en = 1'b1;
    wait_rx(30, 200, ok);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++)
      if (rx_data[i] !== golden[i]) bad++;
    checks++; if (!ok || bad != 0) begin errors++; $display("FAIL en_resume: got %0d bad words of %0d expected 0", bad, rx_data.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    do_reset();
    bus.out_ready = 1'b0;
    en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (dut.fifo_count !== 4'd4) begin errors++; $display("FAIL mid_prefill: got %0d expected 4", dut.fifo_count); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.gen_trig !== 1'b0) begin errors++; $display("FAIL mid_trig: got %b expected 0", bus.gen_trig); end
    checks++; if (dut.fifo_count !== '0) begin errors++; $display("FAIL mid_count: got %0d expected 0", dut.fifo_count); end
    checks++; if (dut.inflight_q !== 2'd0) begin errors++; $display("FAIL mid_inflight: got %0d expected 0", dut.inflight_q); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    wait_rx(10, 100, ok);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++)
      if (rx_data[i] !== golden[i]) bad++;
    checks++; if (!ok || bad != 0) begin errors++; $display("FAIL mid_restart: got %0d bad words of %0d expected 0", bad, rx_data.size()); end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    build_golden();
    test_reset();
    test_raw();
    test_scaled();
    test_stall();
    test_blocks();
    test_en_toggle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
